// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: XLEN, the NOP encoding and the fetch-entry record.
// Also holds the occupancy state encoding used by the fetch queue pointer controller.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  localparam logic [1:0] FQ_EMPTY   = 2'd0;
  localparam logic [1:0] FQ_PARTIAL = 2'd1;
  localparam logic [1:0] FQ_FULL    = 2'd2;

  function automatic logic [1:0] fq_state(input int unsigned count, input int unsigned depth);
    if (count == 32'd0) begin
      return FQ_EMPTY;
    end else if (count == depth) begin
      return FQ_FULL;
    end else begin
      return FQ_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/fetch_queue_fifo_ptr_ctrl.sv
// Pointer, occupancy and EMPTY/PARTIAL/FULL state tracking for the fetch queue.
// Flush dominates enqueue and dequeue and returns everything to zero.
module fetch_queue_fifo_ptr_ctrl
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enq,
  input  logic          i_deq,
  input  logic          i_flush,
  output logic          o_wr_en,
  output logic [PW-1:0] o_wptr,
  output logic [PW-1:0] o_rptr,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;

  // Next-state: pointers wrap by width since DEPTH is a power of two
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    state_d = state_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      state_d = FQ_EMPTY;
    end else begin
      if (i_enq) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (i_deq) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({i_enq, i_deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      state_d = fq_state(32'(count_d), DEPTH);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= FQ_EMPTY;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign o_wr_en = i_enq && !i_flush;
  assign o_wptr  = wptr_q;
  assign o_rptr  = rptr_q;
  assign o_count = count_q;
  assign o_empty = (state_q == FQ_EMPTY);
  assign o_full  = (state_q == FQ_FULL);

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: in-order {pc, instruction} FIFO with flush.
// Optional same-cycle bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned      DEPTH     = 2,
  parameter int unsigned      XLEN      = fetch_queue_pkg::XLEN,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(fetch_queue_pkg::NOP_INSTR)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [XLEN-1:0]            i_instruction,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [XLEN-1:0]            o_pc,
  output logic [XLEN-1:0]            o_instruction,
  input  logic                       i_ready,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  import fetch_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic          enq_s, deq_s, bypass_s, wr_en_s, empty_s, full_s;
  logic [PW-1:0] wptr_s, rptr_s;
  logic [CW-1:0] count_s;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_s = empty_s && i_valid && !i_flush;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed entry that decode takes immediately never touches storage
  assign enq_s = i_valid && !full_s && !(bypass_s && i_ready);
  assign deq_s = !empty_s && i_ready;

  fetch_queue_fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ptr_ctrl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_enq   (enq_s),
    .i_deq   (deq_s),
    .i_flush (i_flush),
    .o_wr_en (wr_en_s),
    .o_wptr  (wptr_s),
    .o_rptr  (rptr_s),
    .o_count (count_s),
    .o_empty (empty_s),
    .o_full  (full_s)
  );

  // Entry storage; contents are intentionally not reset
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      pc_mem_q[wptr_s]    <= i_pc;
      instr_mem_q[wptr_s] <= i_instruction;
    end
  end

  // Head mux: bypass, stored head, or idle NOP
  always_comb begin
    o_valid       = 1'b0;
    o_pc          = '0;
    o_instruction = NOP_INSTR;
    if (bypass_s) begin
      o_valid       = 1'b1;
      o_pc          = i_pc;
      o_instruction = i_instruction;
    end else if (!empty_s) begin
      o_valid       = 1'b1;
      o_pc          = pc_mem_q[rptr_s];
      o_instruction = instr_mem_q[rptr_s];
    end else begin
      o_valid       = 1'b0;
      o_pc          = '0;
      o_instruction = NOP_INSTR;
    end
  end

  assign o_ready = !full_s;
  assign o_count = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table plus reference-FIFO scoreboard.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_i, flush_i;
  logic [31:0] pc_i, instr_i;
  logic        ready_o, valid_o;
  logic [31:0] pc_o, instr_o;
  logic [1:0]  count_o;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .NOP_INSTR(NOP)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid_i),
    .i_pc          (pc_i),
    .i_instruction (instr_i),
    .o_ready       (ready_o),
    .o_valid       (valid_o),
    .o_pc          (pc_o),
    .o_instruction (instr_o),
    .i_ready       (ready_i),
    .i_flush       (flush_i),
    .o_count       (count_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        rdy;
    logic        fl;
    int          e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  logic seen_40  = 1'b0;
  logic last_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, sample at negedge, compare against model, advance model
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input int e_cnt, input logic [31:0] e_pc);
    logic bp, exp_v, acc;
    int   sz;
    ent_t head;
    valid_i = v; pc_i = pc; instr_i = ins; ready_i = rdy; flush_i = fl;
    @(negedge clk);
    sz    = sb.size();
    bp    = BYP && (sz == 0) && v && !fl;
    exp_v = (sz != 0) || bp;
    head  = bp ? ent_t'({pc, ins}) : ((sz != 0) ? sb[0] : ent_t'({32'h0, NOP}));
    chk("count", 32'(count_o), 32'(sz));
    chk("ready", 32'(ready_o), 32'(sz != DEPTH));
    chk("valid", 32'(valid_o), 32'(exp_v));
    chk("pc", pc_o, head.pc);
    chk("instr", instr_o, head.ins);
    if (e_cnt >= 0) begin
      chk("tbl_count", 32'(count_o), 32'(e_cnt));
      if (e_cnt != 0) chk("tbl_pc", pc_o, e_pc);
    end
    last_valid = valid_o;
    if (valid_o && pc_o == 32'h40) seen_40 = 1'b1;
    if (fl) begin
      sb.delete();
    end else begin
      acc = v && (sz != DEPTH);
      if (!(bp && rdy)) begin
        if (exp_v && rdy) void'(sb.pop_front());
        if (acc) sb.push_back({pc, ins});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {v, pc, ins, rdy, fl, expected o_count, expected head pc}
    tbl[0]  = '{1'b1, 32'h0,  32'h0050_0093, 1'b0, 1'b0, 0, 32'h0};
    tbl[1]  = '{1'b1, 32'h4,  32'h00A0_0113, 1'b0, 1'b0, 1, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 2, 32'h0};
    tbl[3]  = '{1'b1, 32'h8,  32'h0030_0193, 1'b1, 1'b0, 2, 32'h0};
    tbl[4]  = '{1'b1, 32'h8,  32'h0030_0193, 1'b1, 1'b0, 1, 32'h4};
    tbl[5]  = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1, 32'h8};
    tbl[6]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 0, 32'h0};
    tbl[7]  = '{1'b1, 32'h10, 32'h0040_0213, 1'b0, 1'b0, 0, 32'h0};
    tbl[8]  = '{1'b1, 32'h14, 32'h0050_0293, 1'b0, 1'b0, 1, 32'h10};
    tbl[9]  = '{1'b1, 32'h40, 32'h0060_0313, 1'b1, 1'b1, 2, 32'h10};
    tbl[10] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 0, 32'h0};
    tbl[11] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 0, 32'h0};

    rst_n = 1'b0; valid_i = 1'b1; pc_i = 32'h300; instr_i = 32'h1234_5678;
    ready_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_ready", 32'(ready_o), 32'h1);
      chk("rst_count", 32'(count_o), 32'h0);
      chk("rst_instr", instr_o, NOP);
      chk("rst_pc", pc_o, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].rdy, tbl[i].fl, tbl[i].e_cnt, tbl[i].e_pc);
    end
    chk("flush_drop_40", 32'(seen_40), 32'h0);

    // Streaming: one bubble at most, at the very start (none with bypass)
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i * 4), 32'h0010_0093 + 32'(i), 1'b1, 1'b0, -1, 32'h0);
      if (last_valid) n_valid++;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, -1, 32'h0);
    if (last_valid) n_valid++;
    chk("stream_no_bubble", 32'(n_valid), 32'd8);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0);

    // Bypass vs. one-cycle latency from empty
    step(1'b1, 32'h100, 32'h0000_0513, 1'b1, 1'b0, 0, 32'h0);
    chk("byp_same_cycle", 32'(last_valid), 32'(BYP));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, BYP ? 0 : 1, 32'h100);
    chk("byp_next_cycle", 32'(last_valid), 32'(!BYP));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0);

    // Asynchronous reset between edges clears outputs immediately
    step(1'b1, 32'h200, 32'h0000_0011, 1'b0, 1'b0, -1, 32'h0);
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_count", 32'(count_o), 32'h0);
    chk("arst_ready", 32'(ready_o), 32'h1);
    chk("arst_instr", instr_o, NOP);
    chk("arst_pc", pc_o, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0);
    step(1'b1, 32'h500, 32'h0000_0713, 1'b0, 1'b0, 0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
